// File: rtl/xmss_pkg.sv
// Shared XMSS constants: ADRS word positions and the L-tree controller state encoding.
`ifndef XMSS_PKG_CLOG2
`define XMSS_PKG_CLOG2
`define CLOG2(x) $clog2(x)
`endif

package xmss_pkg;
  localparam int ADRS_W          = 256;
  localparam int TREE_HEIGHT_MSB = 95;
  localparam int TREE_HEIGHT_LSB = 64;
  localparam int TREE_INDEX_MSB  = 63;
  localparam int TREE_INDEX_LSB  = 32;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_RD   = 4'd1,
    ST_RDW  = 4'd2,
    ST_REQ  = 4'd3,
    ST_WAIT = 4'd4,
    ST_WR   = 4'd5,
    ST_MVR  = 4'd6,
    ST_MVW  = 4'd7,
    ST_NXT  = 4'd8,
    ST_FIN  = 4'd9,
    ST_ERR  = 4'd10
  } lt_state_e;
endpackage

// File: rtl/l_tree_adrs.sv
// Combinational ADRS composer: drops tree height and tree index into a base address.
module l_tree_adrs import xmss_pkg::*; #(
  parameter int AW = 7
) (
  input  logic [ADRS_W-1:0] base,
  input  logic [31:0]       h,
  input  logic [AW-1:0]     i,
  output logic [ADRS_W-1:0] adrs
);
  always_comb begin
    adrs = base;
    adrs[TREE_HEIGHT_MSB:TREE_HEIGHT_LSB] = h;
    adrs[TREE_INDEX_MSB:TREE_INDEX_LSB]   = 32'(i);
  end
endmodule

// File: rtl/l_tree_ctrl.sv
// L-tree compressor controller: folds len_in nodes of a dual-port RAM down to one root
// using an external hash core behind a start/done handshake.
module l_tree_ctrl import xmss_pkg::*; #(
  parameter int KEY_LEN = 256,
  parameter int MAX_LEN = 67,
  parameter int AW      = `CLOG2(MAX_LEN),
  parameter int LW      = `CLOG2(MAX_LEN+1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LW-1:0]        len_in,
  input  logic [ADRS_W-1:0]    hash_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [KEY_LEN-1:0]   leaf_out,
  output logic                 ram_en_0,
  output logic                 ram_we_0,
  output logic [AW-1:0]        ram_addr_0,
  output logic [KEY_LEN-1:0]   ram_din_0,
  input  logic [KEY_LEN-1:0]   ram_dout_0,
  output logic                 ram_en_1,
  output logic                 ram_we_1,
  output logic [AW-1:0]        ram_addr_1,
  output logic [KEY_LEN-1:0]   ram_din_1,
  input  logic [KEY_LEN-1:0]   ram_dout_1,
  output logic                 th_start,
  output logic [2*KEY_LEN-1:0] th_data,
  output logic [ADRS_W-1:0]    th_addr,
  input  logic                 th_done,
  input  logic [KEY_LEN-1:0]   th_dout
);
  lt_state_e           state, state_nx;
  logic [LW-1:0]       l, half;
  logic [31:0]         h;
  logic [AW-1:0]       i;
  logic [ADRS_W-1:0]   base, adrs;
  logic [KEY_LEN-1:0]  hres;
  logic                len_bad, last_pair;

  assign half      = l >> 1;
  assign last_pair = (LW'(i) + LW'(1)) == half;
  assign len_bad   = (len_in == '0) || (len_in > LW'(MAX_LEN));

  l_tree_adrs #(.AW(AW)) u_adrs (.base(base), .h(h), .i(i), .adrs(adrs));

  always_comb begin
    state_nx   = state;
    ram_en_0   = 1'b0;
    ram_we_0   = 1'b0;
    ram_addr_0 = '0;
    ram_din_0  = '0;
    ram_en_1   = 1'b0;
    ram_we_1   = 1'b0;
    ram_addr_1 = '0;
    ram_din_1  = '0;
    th_start   = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nx = len_bad ? ST_ERR : ST_RD;
      ST_RD: begin
        ram_en_0 = 1'b1;
        if (l == LW'(1)) begin
          state_nx = ST_FIN;
        end else begin
          ram_addr_0 = AW'({i, 1'b0});
          ram_en_1   = 1'b1;
          ram_addr_1 = AW'({i, 1'b1});
          state_nx   = ST_RDW;
        end
      end
      ST_RDW:  state_nx = ST_REQ;
      ST_REQ: begin
        th_start = 1'b1;
        state_nx = ST_WAIT;
      end
      ST_WAIT: if (th_done) state_nx = ST_WR;
      ST_WR: begin
        ram_en_0   = 1'b1;
        ram_we_0   = 1'b1;
        ram_addr_0 = i;
        ram_din_0  = hres;
        if (last_pair) state_nx = l[0] ? ST_MVR : ST_NXT;
        else           state_nx = ST_RD;
      end
      // odd trailing node is lifted to slot floor(l/2) through port 1
      ST_MVR: begin
        ram_en_1   = 1'b1;
        ram_addr_1 = AW'(l - LW'(1));
        state_nx   = ST_MVW;
      end
      ST_MVW: begin
        ram_en_1   = 1'b1;
        ram_we_1   = 1'b1;
        ram_addr_1 = AW'(half);
        ram_din_1  = ram_dout_1;
        state_nx   = ST_NXT;
      end
      ST_NXT:  state_nx = ST_RD;
      ST_FIN:  state_nx = ST_IDLE;
      ST_ERR:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      l        <= '0;
      h        <= '0;
      i        <= '0;
      base     <= '0;
      hres     <= '0;
      th_data  <= '0;
      th_addr  <= '0;
      leaf_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state <= state_nx;
      // error completes the cycle after start; a normal run flags done alongside leaf_out
      done  <= (state_nx == ST_ERR) || (state == ST_FIN);
      error <= (state_nx == ST_ERR);
      busy  <= (state_nx != ST_IDLE) && (state_nx != ST_ERR);
      case (state)
        ST_IDLE: if (start && !len_bad) begin
          l    <= len_in;
          h    <= '0;
          i    <= '0;
          base <= hash_addr;
          base[TREE_HEIGHT_MSB:TREE_INDEX_LSB] <= '0;
        end
        ST_RDW: begin
          th_data <= {ram_dout_0, ram_dout_1};
          th_addr <= adrs;
        end
        ST_WAIT: if (th_done) hres <= th_dout;
        ST_WR:   i <= i + AW'(1);
        ST_NXT: begin
          l <= half + LW'(l[0]);
          h <= h + 32'd1;
          i <= '0;
        end
        ST_FIN:  leaf_out <= ram_dout_0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_l_tree_ctrl.sv
// Scoreboard bench for l_tree_ctrl: RAM model, stub hash core H(a,b)=a^rotl(b,1),
// queued expectations for th_addr sequence and done/leaf_out/error.
module tb_l_tree_ctrl;
  import xmss_pkg::*;
  localparam int KEY_LEN = 256;
  localparam int MAX_LEN = 67;
  localparam int AW      = $clog2(MAX_LEN);
  localparam int LW      = $clog2(MAX_LEN+1);

  typedef struct { logic [KEY_LEN-1:0] leaf; logic err; } exp_t;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [LW-1:0] len_in = '0;
  logic [255:0] hash_addr = '0;
  logic busy, done, error;
  logic [KEY_LEN-1:0] leaf_out;
  logic ram_en_0, ram_we_0, ram_en_1, ram_we_1;
  logic [AW-1:0] ram_addr_0, ram_addr_1;
  logic [KEY_LEN-1:0] ram_din_0, ram_din_1, ram_dout_0, ram_dout_1;
  logic th_start;
  logic [2*KEY_LEN-1:0] th_data;
  logic [255:0] th_addr;
  logic th_done = 1'b0;
  logic [KEY_LEN-1:0] th_dout = '0;

  int tests = 0, fails = 0;
  int cyc = 0, wr_cnt = 0, ts_cnt = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  int lat = 1, rem = 0;
  logic load = 1'b0;
  logic [KEY_LEN-1:0] mem [MAX_LEN];
  logic [KEY_LEN-1:0] init_mem [MAX_LEN];
  exp_t exp_q[$];
  logic [255:0] adrs_q[$];
  logic [255:0] last_addr = '0, cap_a = '0;
  logic [2*KEY_LEN-1:0] cap_d = '0;
  logic in_flight = 1'b0, stable = 1'b1, prev_done = 1'b0;

  l_tree_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .len_in(len_in), .hash_addr(hash_addr),
    .busy(busy), .done(done), .error(error), .leaf_out(leaf_out),
    .ram_en_0(ram_en_0), .ram_we_0(ram_we_0), .ram_addr_0(ram_addr_0),
    .ram_din_0(ram_din_0), .ram_dout_0(ram_dout_0),
    .ram_en_1(ram_en_1), .ram_we_1(ram_we_1), .ram_addr_1(ram_addr_1),
    .ram_din_1(ram_din_1), .ram_dout_1(ram_dout_1),
    .th_start(th_start), .th_data(th_data), .th_addr(th_addr),
    .th_done(th_done), .th_dout(th_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [KEY_LEN-1:0] hfn(input logic [KEY_LEN-1:0] a, input logic [KEY_LEN-1:0] b);
    return a ^ {b[KEY_LEN-2:0], b[KEY_LEN-1]};
  endfunction

  function automatic logic [255:0] exp_adrs(input logic [255:0] b, input int hh, input int ii);
    logic [255:0] r;
    r = b;
    r[95:32] = '0;
    r[95:64] = 32'(hh);
    r[63:32] = 32'(ii);
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // dual-port RAM, 1-cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load) begin
      for (int k = 0; k < MAX_LEN; k++) mem[k] <= init_mem[k];
    end else begin
      if (ram_en_0) begin
        if (ram_we_0) mem[ram_addr_0] <= ram_din_0;
        ram_dout_0 <= mem[ram_addr_0];
      end
      if (ram_en_1) begin
        if (ram_we_1) mem[ram_addr_1] <= ram_din_1;
        ram_dout_1 <= mem[ram_addr_1];
      end
      if ((ram_en_0 && ram_we_0) || (ram_en_1 && ram_we_1)) wr_cnt <= wr_cnt + 1;
    end
  end

  // stub hash core with programmable latency, independent of DUT reset
  always @(posedge clk) begin
    th_done <= 1'b0;
    if (th_start) begin
      if (lat <= 1) begin
        th_done <= 1'b1;
        th_dout <= hfn(th_data[2*KEY_LEN-1:KEY_LEN], th_data[KEY_LEN-1:0]);
        rem <= 0;
      end else rem <= lat - 1;
    end else if (rem > 0) begin
      if (rem == 1) begin
        th_done <= 1'b1;
        th_dout <= hfn(th_data[2*KEY_LEN-1:KEY_LEN], th_data[KEY_LEN-1:0]);
      end
      rem <= rem - 1;
    end
  end

  // monitor: pops expectations whenever the DUT presents th_start or done
  always @(negedge clk) begin
    if (reset) begin
      in_flight = 1'b0;
    end else begin
      if (th_start) begin
        ts_cnt++;
        last_addr = th_addr;
        cap_a = th_addr;
        cap_d = th_data;
        in_flight = 1'b1;
        stable = 1'b1;
        if (adrs_q.size() == 0) chk("th_addr_unexpected", th_addr, 256'd0 - 256'd1);
        else chk("th_addr", th_addr, adrs_q.pop_front());
      end else if (in_flight) begin
        if (th_data !== cap_d || th_addr !== cap_a) stable = 1'b0;
        if (th_done) begin
          chk("th_operands_stable", {255'd0, stable}, 256'd1);
          in_flight = 1'b0;
        end
      end
      if (done) begin
        exp_t e;
        done_cnt++;
        done_cyc = cyc;
        chk("done_one_cycle", {255'd0, prev_done}, 256'd0);
        if (exp_q.size() == 0) begin
          chk("done_unexpected", {255'd0, done}, 256'd0);
        end else begin
          e = exp_q.pop_front();
          chk("leaf_out", leaf_out, e.leaf);
          chk("error", {255'd0, error}, {255'd0, e.err});
        end
      end
    end
    prev_done = done;
  end

  task automatic load_mem();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic set5(input logic [KEY_LEN-1:0] a, b, c, d, e);
    for (int k = 0; k < MAX_LEN; k++) init_mem[k] = KEY_LEN'(k) << 200;
    init_mem[0] = a; init_mem[1] = b; init_mem[2] = c; init_mem[3] = d; init_mem[4] = e;
  endtask

  task automatic do_start(input int len, input logic [255:0] b);
    @(negedge clk);
    len_in = LW'(len);
    hash_addr = b;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0, k;
    n0 = done_cnt;
    k = 0;
    while (done_cnt == n0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == n0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic wait_ts(input int n0);
    int k = 0;
    while (ts_cnt == n0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("th_start_seen", {255'd0, ts_cnt != n0}, 256'd1);
  endtask

  // reference L-tree over init_mem, with the ADRS sequence it implies
  task automatic push_tree(input int len, input logic [255:0] b);
    logic [KEY_LEN-1:0] nd [MAX_LEN];
    int l, hh;
    exp_t e;
    for (int k = 0; k < MAX_LEN; k++) nd[k] = init_mem[k];
    l = len;
    hh = 0;
    while (l > 1) begin
      for (int j = 0; j < l/2; j++) begin
        nd[j] = hfn(nd[2*j], nd[2*j+1]);
        adrs_q.push_back(exp_adrs(b, hh, j));
      end
      if (l % 2 == 1) nd[l/2] = nd[l-1];
      l = (l + 1) / 2;
      hh++;
    end
    e.leaf = nd[0];
    e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [255:0] base0, base1;
    exp_t e;
    int ts0, wr0, dn0;
    base0 = {8{32'hDEAD_BEEF}};
    base1 = {8{32'h1234_5678}};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {255'd0, busy}, 256'd0);
    chk("rst_done_error", {254'd0, done, error}, 256'd0);
    chk("rst_th_start", {255'd0, th_start}, 256'd0);
    chk("rst_ram_ctl", {252'd0, ram_en_0, ram_we_0, ram_en_1, ram_we_1}, 256'd0);
    chk("rst_leaf_out", leaf_out, 256'd0);
    chk("rst_th_data", th_data[511:256] | th_data[255:0], 256'd0);
    chk("rst_th_addr", th_addr, 256'd0);
    reset = 1'b0;

    // len 1: no hash, root is node[0], done 3 cycles after start
    set5(256'hABCD, 256'h1, 256'h2, 256'h3, 256'h4);
    load_mem();
    ts0 = ts_cnt;
    e.leaf = 256'hABCD; e.err = 1'b0; exp_q.push_back(e);
    do_start(1, base0);
    wait_done(50);
    chk("len1_latency", 256'(done_cyc - start_cyc), 256'd3);
    chk("len1_no_hash", 256'(ts_cnt - ts0), 256'd0);

    // len 2: H(0x10,0x3) = 0x10 ^ 0x6
    lat = 3;
    set5(256'h10, 256'h3, 256'h0, 256'h0, 256'h0);
    load_mem();
    adrs_q.push_back(exp_adrs(base0, 0, 0));
    e.leaf = 256'h16; exp_q.push_back(e);
    do_start(2, base0);
    wait_done(200);

    // len 3, core latency 5: H(H(1,2),4) = H(5,4) = 13; node[1] holds lifted node[2]
    lat = 5;
    set5(256'h1, 256'h2, 256'h4, 256'h0, 256'h0);
    load_mem();
    adrs_q.push_back(exp_adrs(base1, 0, 0));
    adrs_q.push_back(exp_adrs(base1, 1, 0));
    e.leaf = 256'd13; exp_q.push_back(e);
    do_start(3, base1);
    wait_done(300);
    chk("len3_lifted_node1", mem[1], 256'h4);

    // len 5, latency 1: level0 5,20,16; level1 45,16; root 45^32 = 13
    lat = 1;
    set5(256'h1, 256'h2, 256'h4, 256'h8, 256'h10);
    load_mem();
    adrs_q.push_back(exp_adrs(base0, 0, 0));
    adrs_q.push_back(exp_adrs(base0, 0, 1));
    adrs_q.push_back(exp_adrs(base0, 1, 0));
    adrs_q.push_back(exp_adrs(base0, 2, 0));
    e.leaf = 256'd13; exp_q.push_back(e);
    do_start(5, base0);
    wait_done(300);

    // illegal lengths: error one cycle after start, leaf_out held, no RAM write / hash
    for (int t = 0; t < 2; t++) begin
      ts0 = ts_cnt;
      wr0 = wr_cnt;
      e.leaf = 256'd13; e.err = 1'b1; exp_q.push_back(e);
      do_start(t == 0 ? 0 : MAX_LEN + 1, base1);
      wait_done(20);
      repeat (3) @(negedge clk);
      chk("err_latency", 256'(done_cyc - start_cyc), 256'd1);
      chk("err_no_write", 256'(wr_cnt - wr0), 256'd0);
      chk("err_no_hash", 256'(ts_cnt - ts0), 256'd0);
    end

    // start pulsed while waiting on the core is ignored
    lat = 40;
    set5(256'h1, 256'h2, 256'h4, 256'h0, 256'h0);
    load_mem();
    adrs_q.push_back(exp_adrs(base0, 0, 0));
    adrs_q.push_back(exp_adrs(base0, 1, 0));
    e.leaf = 256'd13; e.err = 1'b0; exp_q.push_back(e);
    ts0 = ts_cnt;
    dn0 = done_cnt;
    do_start(3, base0);
    wait_ts(ts0);
    repeat (5) @(negedge clk);
    len_in = '0;
    hash_addr = base1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(500);
    repeat (20) @(negedge clk);
    chk("busy_start_one_done", 256'(done_cnt - dn0), 256'd1);

    // reset while waiting: late th_done must not cause a write or done
    set5(256'h1, 256'h2, 256'h4, 256'h8, 256'h10);
    load_mem();
    adrs_q.push_back(exp_adrs(base0, 0, 0));
    ts0 = ts_cnt;
    do_start(5, base0);
    wait_ts(ts0);
    repeat (3) @(negedge clk);
    ts0 = ts_cnt;
    wr0 = wr_cnt;
    dn0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    chk("abort_no_write", 256'(wr_cnt - wr0), 256'd0);
    chk("abort_no_done", 256'(done_cnt - dn0), 256'd0);
    chk("abort_no_hash", 256'(ts_cnt - ts0), 256'd0);

    // fresh run after the abort
    lat = 1;
    load_mem();
    adrs_q.push_back(exp_adrs(base1, 0, 0));
    adrs_q.push_back(exp_adrs(base1, 0, 1));
    adrs_q.push_back(exp_adrs(base1, 1, 0));
    adrs_q.push_back(exp_adrs(base1, 2, 0));
    e.leaf = 256'd13; e.err = 1'b0; exp_q.push_back(e);
    do_start(5, base1);
    wait_done(300);

    // full-length leaf at core latency 1 and 40
    for (int t = 0; t < 2; t++) begin
      lat = (t == 0) ? 1 : 40;
      for (int k = 0; k < MAX_LEN; k++)
        init_mem[k] = {8{32'h1000_0000 ^ (32'(k) * 32'h9E37_79B9)}} ^ (KEY_LEN'(t) << 100);
      load_mem();
      push_tree(MAX_LEN, base0);
      ts0 = ts_cnt;
      do_start(MAX_LEN, base0);
      wait_done(6000);
      chk("max_hash_count", 256'(ts_cnt - ts0), 256'd66);
      chk("max_last_height", {224'd0, last_addr[95:64]}, 256'd6);
      chk("max_last_index", {224'd0, last_addr[63:32]}, 256'd0);
    end

    repeat (5) @(negedge clk);
    chk("exp_q_drained", 256'(exp_q.size()), 256'd0);
    chk("adrs_q_drained", 256'(adrs_q.size()), 256'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
